// File: rtl/des_key_sched_seq_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: PC1/PC2 permutations, the per-round
// rotation schedule, 28-bit rotate helpers and the sequencer state enum.
// Used by the sequential key scheduler, the combinational key generator and
// the round datapath.
// Bit numbering: DES bit 1 is the MSB of every vector.
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Left-rotation amount applied before round i (index 0 = round 1).
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // 64-bit key -> 56-bit {C,D}; the eight parity bits are dropped.
  function automatic logic [55:0] des_pc1(input logic [63:0] key);
    logic [55:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) res[55-i] = key[64-PC1_TAB[i]];
    return res;
  endfunction

  // 56-bit {C,D} -> 48-bit round subkey.
  function automatic logic [47:0] des_pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = '0;
    for (int i = 0; i < 48; i++) res[47-i] = cd[56-PC2_TAB[i]];
    return res;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_sched_seq_if.sv
// -----------------------------------------------------------------------------
// des_key_sched_seq_if
// Handshake bundle of the sequential DES key scheduler.
//   start side : key_in, decrypt, start_valid -> start_ready
//   key side   : key_valid, key_out, key_round, key_last -> key_ready
//   control    : flush (synchronous abort)
// modport master = job issuer / key consumer, modport slave = scheduler.
// -----------------------------------------------------------------------------
interface des_key_sched_seq_if;

  logic [63:0] key_in;
  logic        decrypt;
  logic        start_valid;
  logic        start_ready;
  logic        flush;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] key_out;
  logic [3:0]  key_round;
  logic        key_last;

  modport master (
    output key_in, decrypt, start_valid, flush, key_ready,
    input  start_ready, key_valid, key_out, key_round, key_last
  );

  modport slave (
    input  key_in, decrypt, start_valid, flush, key_ready,
    output start_ready, key_valid, key_out, key_round, key_last
  );

endinterface

// File: rtl/des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// des_key_sched_seq
// Iterative DES key schedule. A key accepted in IDLE is loaded through PC1
// into one C/D register pair; each accepted subkey then rotates C/D in place,
// giving the first NUM_KEYS subkeys in encrypt (K1..) or decrypt (K16..)
// order, one per key handshake.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - des_key_sched_seq_if.slave (start / key handshakes, flush)
// Every output is decoded from registers only: no path from key_ready or
// start_valid to any output.
// -----------------------------------------------------------------------------
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int NUM_KEYS      = 16,
  parameter int KEY_OUT_WIDTH = 48
) (
  input logic               clk,
  input logic               rst_n,
  des_key_sched_seq_if.slave bus
);

  if (KEY_OUT_WIDTH != 48) begin : g_bad_width
    $error("des_key_sched_seq: KEY_OUT_WIDTH must be 48");
  end
  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("des_key_sched_seq: NUM_KEYS must be in 1..16");
  end

  localparam logic [3:0] LAST_CNT = 4'(NUM_KEYS - 1);

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_mode;   // 1 = decrypt order

  logic [55:0] w_pc1;
  logic        w_last;
  logic [3:0]  w_idx_fwd;
  logic [3:0]  w_idx_rev;

  assign w_pc1     = des_pc1(bus.key_in);
  assign w_last    = (r_state == ST_EMIT) && (r_cnt == LAST_CNT);
  // Encrypt steps forward to the shift of the next round; decrypt undoes the
  // shift of the round just emitted (key cnt in decrypt order is K16-cnt).
  assign w_idx_fwd = r_cnt + 4'd1;
  assign w_idx_rev = 4'd15 - r_cnt;

  // NOTE: every state register uses non-blocking assignment so all updates
  // within an edge see the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else if (bus.flush) begin
      // C/D are left as-is: they are reloaded on the next accept.
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_mode  <= bus.decrypt;
            r_cnt   <= '0;
            r_state <= ST_EMIT;
            if (bus.decrypt) begin
              // C16/D16 equal C0/D0 (total rotation is 28), so K16 needs none.
              r_c <= w_pc1[55:28];
              r_d <= w_pc1[27:0];
            end else begin
              r_c <= rotl28(w_pc1[55:28], SHIFT[0]);
              r_d <= rotl28(w_pc1[27:0],  SHIFT[0]);
            end
          end
        end
        ST_EMIT: begin
          if (bus.key_ready) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              if (r_mode) begin
                r_c <= rotr28(r_c, SHIFT[w_idx_rev]);
                r_d <= rotr28(r_d, SHIFT[w_idx_rev]);
              end else begin
                r_c <= rotl28(r_c, SHIFT[w_idx_fwd]);
                r_d <= rotl28(r_d, SHIFT[w_idx_fwd]);
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.key_valid   = (r_state == ST_EMIT);
  assign bus.key_out     = des_pc2({r_c, r_d});
  assign bus.key_round   = r_mode ? (4'd15 - r_cnt) : r_cnt;
  assign bus.key_last    = w_last;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// tb_des_key_sched_seq
// Two schedulers (NUM_KEYS = 16 and NUM_KEYS = 4) driven by a job issuer that
// pushes the expected subkeys of each accepted job into a per-DUT queue; a
// negedge monitor compares every presented subkey with the queue head and
// pops on handshake. The reference model builds each round key directly from
// the key bits: C_r/D_r are C0/D0 rotated by the cumulative schedule total.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_des_key_sched_seq;

  typedef logic [15:0][47:0] ks_t;
  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  round;
    logic        last;
  } exp_t;

  localparam int REF_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int REF_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int REF_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] KAT_KEY = 64'h1334_5779_9BBC_DFF1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_sched_seq_if if16 ();
  des_key_sched_seq_if if4 ();

  des_key_sched_seq #(.NUM_KEYS(16), .KEY_OUT_WIDTH(48)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
  );
  des_key_sched_seq #(.NUM_KEYS(4), .KEY_OUT_WIDTH(48)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q16[$];
  exp_t        q4[$];
  logic [47:0] log16[$];
  logic [47:0] log4[$];
  int          acc16 = 0;
  bit          rnd16 = 1'b0;
  bit          rnd4  = 1'b0;

  // Round keys K1..K16 computed straight from the key bit positions.
  function automatic ks_t ref_keys(input logic [63:0] key);
    logic c0 [28];
    logic d0 [28];
    ks_t  ks;
    int   tot;
    int   p;
    for (int i = 0; i < 28; i++) begin
      c0[i] = key[64-REF_PC1[i]];
      d0[i] = key[64-REF_PC1[i+28]];
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += REF_SH[r];
      for (int b = 0; b < 48; b++) begin
        p = REF_PC2[b] - 1;
        ks[r][47-b] = (p < 28) ? c0[(p + tot) % 28] : d0[(p - 28 + tot) % 28];
      end
    end
    return ks;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_cmp(input string tag, input logic [47:0] k, input logic [3:0] r,
                         input logic l, input exp_t e);
    check({tag, "_key"},   64'(k), 64'(e.key));
    check({tag, "_round"}, 64'(r), 64'(e.round));
    check({tag, "_last"},  64'(l), 64'(e.last));
  endtask

  // Monitors: every presented key must match the queue head (this also covers
  // holding while stalled); it is consumed only when key_ready is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if16.flush) q16.delete();
      else if (if16.key_valid) begin
        if (q16.size() == 0) check("k16_unexpected_key", 64'(if16.key_out), 64'hx);
        else begin
          mon_cmp("k16", if16.key_out, if16.key_round, if16.key_last, q16[0]);
          if (if16.key_ready) begin
            log16.push_back(if16.key_out);
            void'(q16.pop_front());
            acc16++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if4.flush) q4.delete();
      else if (if4.key_valid) begin
        if (q4.size() == 0) check("k4_unexpected_key", 64'(if4.key_out), 64'hx);
        else begin
          mon_cmp("k4", if4.key_out, if4.key_round, if4.key_last, q4[0]);
          if (if4.key_ready) begin
            log4.push_back(if4.key_out);
            void'(q4.pop_front());
          end
        end
      end
    end
  end

  // Consumer readiness, randomised when backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if16.key_ready = rnd16 ? 1'($urandom_range(0, 1)) : 1'b1;
      if4.key_ready  = rnd4  ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_job(input bit sel, input logic [63:0] k, input logic dec);
    int   t;
    int   n;
    int   r;
    exp_t e;
    ks_t  ks;
    t = 0;
    while ((sel ? !if4.start_ready : !if16.start_ready) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(sel ? "k4_start_ready_wait" : "k16_start_ready_wait", 64'(t < 200), 64'd1);
    @(posedge clk);
    #1;
    ks = ref_keys(k);
    n  = sel ? 4 : 16;
    for (int i = 0; i < n; i++) begin
      r       = dec ? 15 - i : i;
      e.key   = ks[r];
      e.round = 4'(r);
      e.last  = (i == n - 1);
      if (sel) q4.push_back(e);
      else     q16.push_back(e);
    end
    if (sel) begin
      if4.key_in = k; if4.decrypt = dec; if4.start_valid = 1'b1;
    end else begin
      acc16 = 0;
      if16.key_in = k; if16.decrypt = dec; if16.start_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sel) begin
      if4.start_valid = 1'b0; if4.key_in = {$urandom, $urandom}; if4.decrypt = 1'($urandom);
    end else begin
      if16.start_valid = 1'b0; if16.key_in = {$urandom, $urandom}; if16.decrypt = 1'($urandom);
    end
  endtask

  task automatic wait_done(input bit sel);
    int t;
    t = 0;
    while (t < 3000 && (sel ? (q4.size() != 0 || !if4.start_ready)
                            : (q16.size() != 0 || !if16.start_ready))) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(sel ? "k4_job_done" : "k16_job_done", 64'(t < 3000), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag, input logic sr, input logic kv,
                                     input logic [47:0] ko, input logic [3:0] kr, input logic kl);
    check({tag, "_rst_start_ready"}, 64'(sr), 64'd1);
    check({tag, "_rst_key_valid"},   64'(kv), 64'd0);
    check({tag, "_rst_key_out"},     64'(ko), 64'd0);
    check({tag, "_rst_key_round"},   64'(kr), 64'd0);
    check({tag, "_rst_key_last"},    64'(kl), 64'd0);
  endtask

  initial begin
    logic [47:0] ref_log [$];
    int          t;
    // NOTE: stimulus is driven with blocking assignments just after the
    // active edge, so the DUT always samples settled values.
    if16.key_in = '0; if16.decrypt = 1'b0; if16.start_valid = 1'b0; if16.flush = 1'b0;
    if16.key_ready = 1'b1;
    if4.key_in = '0;  if4.decrypt = 1'b0;  if4.start_valid = 1'b0;  if4.flush = 1'b0;
    if4.key_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("k16", if16.start_ready, if16.key_valid, if16.key_out,
                        if16.key_round, if16.key_last);
    check_reset_outputs("k4", if4.start_ready, if4.key_valid, if4.key_out,
                        if4.key_round, if4.key_last);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Encrypt known answer, key_ready high: 16 back-to-back keys then a bubble.
    log16.delete();
    start_job(1'b0, KAT_KEY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("enc_stream_valid", 64'(if16.key_valid), 64'd1);
    end
    @(negedge clk);
    check("enc_bubble_valid", 64'(if16.key_valid), 64'd0);
    check("enc_bubble_ready", 64'(if16.start_ready), 64'd1);
    check("enc_kat_count", 64'(log16.size()), 64'd16);
    if (log16.size() == 16) begin
      check("enc_kat_k1",  64'(log16[0]),  64'h1B02EFFC7072);
      check("enc_kat_k2",  64'(log16[1]),  64'h79AED9DBC9E5);
      check("enc_kat_k16", 64'(log16[15]), 64'hCB3D8B0E17F5);
    end
    ref_log = log16;

    // Decrypt known answer.
    log16.delete();
    start_job(1'b0, KAT_KEY, 1'b1);
    wait_done(1'b0);
    check("dec_kat_count", 64'(log16.size()), 64'd16);
    if (log16.size() == 16) begin
      check("dec_kat_first", 64'(log16[0]),  64'hCB3D8B0E17F5);
      check("dec_kat_last",  64'(log16[15]), 64'h1B02EFFC7072);
    end

    // Same encrypt job under random backpressure: identical sequence.
    log16.delete();
    rnd16 = 1'b1;
    start_job(1'b0, KAT_KEY, 1'b0);
    wait_done(1'b0);
    rnd16 = 1'b0;
    check("bp_count", 64'(log16.size()), 64'd16);
    for (int i = 0; i < 16 && i < log16.size(); i++)
      check("bp_seq", 64'(log16[i]), 64'(ref_log[i]));

    // start_valid during EMIT must be ignored.
    start_job(1'b0, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("emit_start_ready", 64'(if16.start_ready), 64'd0);
      if16.start_valid = 1'b1;
      if16.key_in = {$urandom, $urandom};
      if16.decrypt = 1'($urandom);
      @(posedge clk);
      #1;
    end
    if16.start_valid = 1'b0;
    wait_done(1'b0);

    // Flush at cnt = 5 of a decrypt job, then a fresh encrypt job.
    start_job(1'b0, KAT_KEY, 1'b1);
    t = 0;
    while (acc16 < 5 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("flush_reach_cnt5", 64'(acc16), 64'd5);
    #1 if16.flush = 1'b1;
    @(posedge clk);
    #1 if16.flush = 1'b0;
    @(negedge clk);
    check("flush_key_valid", 64'(if16.key_valid), 64'd0);
    check("flush_start_ready", 64'(if16.start_ready), 64'd1);
    log16.delete();
    start_job(1'b0, KAT_KEY, 1'b0);
    wait_done(1'b0);
    if (log16.size() > 0) check("post_flush_k1", 64'(log16[0]), 64'h1B02EFFC7072);
    else check("post_flush_count", 64'(log16.size()), 64'd16);

    // NUM_KEYS = 4: known answer, exactly four keys.
    log4.delete();
    start_job(1'b1, KAT_KEY, 1'b0);
    wait_done(1'b1);
    check("k4_count", 64'(log4.size()), 64'd4);
    if (log4.size() > 0) check("k4_kat_k1", 64'(log4[0]), 64'h1B02EFFC7072);

    // Random keys, both orders, both depths, random backpressure.
    rnd16 = 1'b1;
    rnd4  = 1'b1;
    for (int j = 0; j < 24; j++) begin
      bit sel;
      sel = 1'($urandom);
      start_job(sel, {$urandom, $urandom}, 1'($urandom));
      wait_done(sel);
    end
    rnd16 = 1'b0;
    rnd4  = 1'b0;

    // Asynchronous reset mid-job: outputs return to reset values with no edge.
    start_job(1'b1, {$urandom, $urandom}, 1'b1);
    start_job(1'b0, {$urandom, $urandom}, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("k16_mid", if16.start_ready, if16.key_valid, if16.key_out,
                        if16.key_round, if16.key_last);
    check_reset_outputs("k4_mid", if4.start_ready, if4.key_valid, if4.key_out,
                        if4.key_round, if4.key_last);
    q16.delete();
    q4.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle16", 64'(if16.key_valid), 64'd0);
    check("post_reset_idle4",  64'(if4.key_valid),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
